valu_iter: RTL and testbench
============================

// Module: valu_iter
// PURPOSE
//  Multi-beat, parametrised successor of the combinational vector ALU: VLEN-bit operands processed DP_W bits per cycle.
//  Adds vl/mask/tail handling and valid/ready handshakes on input and output.
//  Sits between vector register-file read and writeback; reuses the vALU op/SEW encoding.
// PARAMETERS
//  VLEN  128  vector register width in bits; multiple of DP_W
//  DP_W   64  datapath bits per beat; multiple of 64
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst            in   1         synchronous, active-high reset
//  in_valid       in   1         operation request
//  in_ready       out  1         block can accept a request
//  valu_op        in   4         vALU op code (0000..1011)
//  SEW            in   3         000=8, 001=16, 010=32, 011=64 bit elements
//  vl             in   $clog2(VLEN/8)+1  active element count
//  vm             in   1         1=unmasked; 0=use mask
//  mask           in   VLEN/8    mask bit per element index e
//  reg_in1        in   VLEN      vector operand 1
//  reg_in2        in   VLEN      vector operand 2
//  reg_old        in   VLEN      old destination value (inactive/tail elements)
//  reg_scalar_in  in   64        scalar/immediate operand; low SEW bits used
//  out_valid      out  1         result valid
//  out_ready      in   1         consumer accepts result
//  result         out  VLEN      result vector
//  illegal        out  1         op/SEW unsupported; qualified by out_valid
//  busy           out  1         high in EXEC or DONE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, illegal=0, result=0.
//  Reset mid-operation aborts; captured operands are discarded, no out_valid.
//  FSM: IDLE --(in_valid&in_ready)--> EXEC; EXEC --(beat==NBEATS-1)--> DONE;
//   DONE --(out_ready)--> IDLE. NBEATS=VLEN/DP_W.
//  IDLE: in_ready=1. All inputs are captured on the accept edge; later input changes are ignored.
//  EXEC: beat k writes result[k*DP_W +: DP_W]; in_ready=0; one beat per cycle.
//  Latency: out_valid rises NBEATS cycles after the accept edge.
//  DONE: result/illegal held stable while out_valid=1 and out_ready=0.
//  in_ready=0 in DONE; the next accept is possible the cycle after out_valid&out_ready.
//  Ops: 0000 vv add, 0001 vx add, 0010 vv sub, 0011 vx sub, 0100 vv mul, 0101 vx mul,
//   0110 vv and, 0111 vx and, 1000 vv or, 1001 vx or, 1010 vv xor, 1011 vx xor.
//   vx = reg_in1 element op scalar[SEW-1:0].
//  Arithmetic: modular in SEW bits, no carry between elements.
//   mul is signed SEW x SEW; keep the low SEW bits.
//  All SEWs, including 64, use the named logic op (vx or/xor fixed vs. vALU).
//  Element e (index across the whole vector) is active iff e<vl_eff && (vm || mask[e]).
//  vl_eff = min(vl, VLEN/SEW). Inactive or tail element -> reg_old element (undisturbed).
//  vl=0: result=reg_old, still NBEATS latency.
//  Illegal (SEW>011 or op>1011): result=0, illegal=1; timing is unchanged.
// TESTING
//  VLEN=128, DP_W=64, SEW=000, op 0000, vl=16, vm=1, in1 bytes=8'hFF, in2=8'h02
//   -> every byte 8'h01, out_valid 2 cycles after accept.
//  SEW=010, op 0101, in1 words=32'hFFFF_FFFE (-2), scalar=3
//   -> each word 32'hFFFF_FFFA.
//  SEW=001, op 0010, vl=5, vm=0, mask=8'b0001_0101, reg_old=all 16'hAAAA
//   -> elems 0,2,4 computed; all others 16'hAAAA.
//  SEW=011, op 1001 and op 1011, in1=64'hF0F0.., scalar=64'h0FF0..
//   -> OR / XOR results, never AND.
//  Hold out_ready=0 5 cycles -> result stable, in_ready=0, in_valid ignored; then release -> in_ready=1 next cycle.
//  Assert rst during EXEC -> next cycle out_valid=0, in_ready=1, result=0.
//  SEW=100 -> illegal=1, result=0.

Source files
------------

// File: rtl/valu_iter_if.sv
// valu_iter_if: request/response bundle between the vector register-file read
// stage, the iterative vector ALU and writeback.
//   master : drives the request (in_valid, op, SEW, vl, vm, mask, operands,
//            scalar) and out_ready; observes in_ready, out_valid, result,
//            illegal, busy.
//   slave  : the ALU side (valu_iter).
// SEW keeps its upper-case name for continuity with the combinational vALU.
interface valu_iter_if #(
  parameter int VLEN = 128
) ();
  localparam int VL_W = $clog2(VLEN/8) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        valu_op;
  logic [2:0]        SEW;
  logic [VL_W-1:0]   vl;
  logic              vm;
  logic [VLEN/8-1:0] mask;
  logic [VLEN-1:0]   reg_in1;
  logic [VLEN-1:0]   reg_in2;
  logic [VLEN-1:0]   reg_old;
  logic [63:0]       reg_scalar_in;
  logic              out_valid;
  logic              out_ready;
  logic [VLEN-1:0]   result;
  logic              illegal;
  logic              busy;

  modport master (
    output in_valid, valu_op, SEW, vl, vm, mask, reg_in1, reg_in2, reg_old,
           reg_scalar_in, out_ready,
    input  in_ready, out_valid, result, illegal, busy
  );

  modport slave (
    input  in_valid, valu_op, SEW, vl, vm, mask, reg_in1, reg_in2, reg_old,
           reg_scalar_in, out_ready,
    output in_ready, out_valid, result, illegal, busy
  );
endinterface

// File: rtl/valu_iter.sv
// valu_iter: multi-beat vector ALU. A VLEN-bit operation is accepted in one
// cycle, then processed DP_W bits per cycle; the finished vector is presented
// with out_valid until out_ready. Supports vl/mask/tail-undisturbed handling.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - valu_iter_if.slave (request handshake, operands, result handshake)
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request; inputs captured on accept
// EXEC  | one DP_W-bit beat of the result written per cycle
// DONE  | result/illegal held, out_valid=1 until out_ready
module valu_iter #(
  parameter int VLEN = 128,
  parameter int DP_W = 64
) (
  input  logic       clk,
  input  logic       rst,
  valu_iter_if.slave bus
);
  localparam int NBEATS = VLEN / DP_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int NMASK  = VLEN / 8;
  localparam int MIDX_W = $clog2(NMASK);
  localparam int VL_W   = $clog2(VLEN/8) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nxt;

  logic [BEAT_W-1:0] beat;
  logic              last_beat;
  logic              accept;

  logic [3:0]        op_q;
  logic [2:0]        sew_q;
  logic [VL_W-1:0]   vl_q;
  logic              vm_q;
  logic [NMASK-1:0]  mask_q;
  logic [VLEN-1:0]   in1_q, in2_q, old_q;
  logic [63:0]       scalar_q;
  logic              illegal_q;
  logic [VLEN-1:0]   result_q;

  logic [DP_W-1:0]   a_c, b_c, old_c, beat_res;
  logic [MIDX_W-1:0] e_idx;
  logic [63:0]       r;

  // Operands are zero-extended to 64 bits and the caller keeps the low SEW
  // bits, so unsigned multiply gives the same low bits as signed multiply.
  function automatic logic [63:0] elem_op(input logic [3:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] res;
    case (op[3:1])
      3'd0:    res = a + b;
      3'd1:    res = a - b;
      3'd2:    res = a * b;
      3'd3:    res = a & b;
      3'd4:    res = a | b;
      3'd5:    res = a ^ b;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign last_beat = (beat == BEAT_W'(NBEATS - 1));
  assign accept    = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        bus.busy = 1'b1;
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One beat of lanes. Element index e is global across the vector, so the
  // beat number is folded into the mask/vl comparison. vl_eff clamping is
  // implicit: every element index reached is already below VLEN/SEW.
  always_comb begin
    a_c      = DP_W'(in1_q >> (int'(beat) * DP_W));
    b_c      = DP_W'(in2_q >> (int'(beat) * DP_W));
    old_c    = DP_W'(old_q >> (int'(beat) * DP_W));
    beat_res = old_c;
    e_idx    = '0;
    r        = '0;
    case (sew_q)
      3'd0: for (int i = 0; i < DP_W/8; i++) begin
        e_idx = MIDX_W'(int'(beat) * (DP_W/8) + i);
        r = elem_op(op_q, 64'(a_c[i*8 +: 8]),
                    op_q[0] ? 64'(scalar_q[7:0]) : 64'(b_c[i*8 +: 8]));
        beat_res[i*8 +: 8] = ((VL_W'(e_idx) < vl_q) && (vm_q || mask_q[e_idx]))
                             ? r[7:0] : old_c[i*8 +: 8];
      end
      3'd1: for (int i = 0; i < DP_W/16; i++) begin
        e_idx = MIDX_W'(int'(beat) * (DP_W/16) + i);
        r = elem_op(op_q, 64'(a_c[i*16 +: 16]),
                    op_q[0] ? 64'(scalar_q[15:0]) : 64'(b_c[i*16 +: 16]));
        beat_res[i*16 +: 16] = ((VL_W'(e_idx) < vl_q) && (vm_q || mask_q[e_idx]))
                               ? r[15:0] : old_c[i*16 +: 16];
      end
      3'd2: for (int i = 0; i < DP_W/32; i++) begin
        e_idx = MIDX_W'(int'(beat) * (DP_W/32) + i);
        r = elem_op(op_q, 64'(a_c[i*32 +: 32]),
                    op_q[0] ? 64'(scalar_q[31:0]) : 64'(b_c[i*32 +: 32]));
        beat_res[i*32 +: 32] = ((VL_W'(e_idx) < vl_q) && (vm_q || mask_q[e_idx]))
                               ? r[31:0] : old_c[i*32 +: 32];
      end
      3'd3: for (int i = 0; i < DP_W/64; i++) begin
        e_idx = MIDX_W'(int'(beat) * (DP_W/64) + i);
        r = elem_op(op_q, a_c[i*64 +: 64], op_q[0] ? scalar_q : b_c[i*64 +: 64]);
        beat_res[i*64 +: 64] = ((VL_W'(e_idx) < vl_q) && (vm_q || mask_q[e_idx]))
                               ? r : old_c[i*64 +: 64];
      end
      default: beat_res = '0;
    endcase
    if (illegal_q) beat_res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat      <= '0;
      op_q      <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      mask_q    <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      old_q     <= '0;
      scalar_q  <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      beat      <= '0;
      op_q      <= bus.valu_op;
      sew_q     <= bus.SEW;
      vl_q      <= bus.vl;
      vm_q      <= bus.vm;
      mask_q    <= bus.mask;
      in1_q     <= bus.reg_in1;
      in2_q     <= bus.reg_in2;
      old_q     <= bus.reg_old;
      scalar_q  <= bus.reg_scalar_in;
      illegal_q <= (bus.SEW > 3'b011) || (bus.valu_op > 4'b1011);
    end else if (state == EXEC) begin
      for (int k = 0; k < NBEATS; k++) begin
        if (beat == BEAT_W'(k)) result_q[k*DP_W +: DP_W] <= beat_res;
      end
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_valu_iter.sv
module tb_valu_iter;
  localparam int VLEN   = 128;
  localparam int DP_W   = 64;
  localparam int NBEATS = VLEN / DP_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  valu_iter_if #(.VLEN(VLEN)) bus ();
  valu_iter #(.VLEN(VLEN), .DP_W(DP_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Element-level reference: signed multiply via sign extension, vl clamp,
  // mask and tail-undisturbed, all in plain arithmetic.
  function automatic logic [VLEN-1:0] model(
      input logic [3:0] op, input logic [2:0] sew, input int vl, input logic vm,
      input logic [VLEN/8-1:0] mask, input logic [VLEN-1:0] in1,
      input logic [VLEN-1:0] in2, input logic [VLEN-1:0] old,
      input logic [63:0] sc, output logic ill);
    logic [VLEN-1:0] res;
    logic [63:0] m, h, a, b, o, sa, sb, rr;
    int w, n, vle;
    logic act;
    ill = (sew > 3) || (op > 11);
    if (ill) return '0;
    w   = 8 << sew;
    n   = VLEN / w;
    vle = (vl < n) ? vl : n;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    h   = 64'd1 << (w - 1);
    res = '0;
    for (int e = 0; e < n; e++) begin
      a = 64'(in1 >> (e * w)) & m;
      b = op[0] ? (sc & m) : (64'(in2 >> (e * w)) & m);
      o = 64'(old >> (e * w)) & m;
      sa = (a ^ h) - h;
      sb = (b ^ h) - h;
      case (op >> 1)
        0: rr = a + b;
        1: rr = a - b;
        2: rr = sa * sb;
        3: rr = a & b;
        4: rr = a | b;
        default: rr = a ^ b;
      endcase
      act = (e < vle) && (vm || (((mask >> e) & 1) != 0));
      res = res | (VLEN'((act ? rr : o) & m) << (e * w));
    end
    return res;
  endfunction

  task automatic scramble_inputs();
    bus.valu_op       = 4'($urandom);
    bus.SEW           = 3'($urandom);
    bus.vl            = 5'($urandom);
    bus.vm            = 1'($urandom);
    bus.mask          = 16'($urandom);
    bus.reg_in1       = {$urandom, $urandom, $urandom, $urandom};
    bus.reg_in2       = {$urandom, $urandom, $urandom, $urandom};
    bus.reg_old       = {$urandom, $urandom, $urandom, $urandom};
    bus.reg_scalar_in = {$urandom, $urandom};
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] sew, input int vl,
                       input logic vm, input logic [15:0] mask,
                       input logic [VLEN-1:0] in1, input logic [VLEN-1:0] in2,
                       input logic [VLEN-1:0] old, input logic [63:0] sc);
    bus.valu_op       = op;
    bus.SEW           = sew;
    bus.vl            = 5'(vl);
    bus.vm            = vm;
    bus.mask          = mask;
    bus.reg_in1       = in1;
    bus.reg_in2       = in2;
    bus.reg_old       = old;
    bus.reg_scalar_in = sc;
  endtask

  // Issue one op, scramble inputs right after the accept edge, wait (bounded)
  // for out_valid, sample, then complete the output handshake.
  task automatic run_op(input logic [3:0] op, input logic [2:0] sew, input int vl,
                        input logic vm, input logic [15:0] mask,
                        input logic [VLEN-1:0] in1, input logic [VLEN-1:0] in2,
                        input logic [VLEN-1:0] old, input logic [63:0] sc,
                        output logic [VLEN-1:0] res, output logic ill, output int lat);
    @(negedge clk);
    drive(op, sew, vl, vm, mask, in1, in2, old, sc);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    ill = bus.illegal;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", bus.illegal); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [VLEN-1:0] res, exp;
    logic ill;
    int lat;
    // byte add, wrap per element
    run_op(4'b0000, 3'b000, 16, 1'b1, 16'h0, {16{8'hFF}}, {16{8'h02}}, '0, 64'h0, res, ill, lat);
    checks++; if (res !== {16{8'h01}}) begin errors++; $display("FAIL add8 got %h want %h", res, {16{8'h01}}); end
    checks++; if (lat !== NBEATS) begin errors++; $display("FAIL add8_latency got %0d want %0d", lat, NBEATS); end
    checks++; if (ill !== 1'b0) begin errors++; $display("FAIL add8_illegal got %b want 0", ill); end
    // signed vx mul
    run_op(4'b0101, 3'b010, 16, 1'b1, 16'h0, {4{32'hFFFF_FFFE}}, {4{32'h1234_5678}}, '0, 64'h3, res, ill, lat);
    checks++; if (res !== {4{32'hFFFF_FFFA}}) begin errors++; $display("FAIL mul32_vx got %h want %h", res, {4{32'hFFFF_FFFA}}); end
    // masked sub with tail
    exp = {8{16'hAAAA}};
    exp[15:0] = 16'h000D; exp[47:32] = 16'h000D; exp[79:64] = 16'h000D;
    run_op(4'b0010, 3'b001, 5, 1'b0, 16'h0015, {8{16'h0010}}, {8{16'h0003}}, {8{16'hAAAA}}, 64'h0, res, ill, lat);
    checks++; if (res !== exp) begin errors++; $display("FAIL sub16_mask got %h want %h", res, exp); end
    // 64-bit vx or / xor
    run_op(4'b1001, 3'b011, 2, 1'b1, 16'h0, {2{64'hF0F0_F0F0_F0F0_F0F0}}, '0, '0, 64'h0FF0_0FF0_0FF0_0FF0, res, ill, lat);
    checks++; if (res !== {2{64'hFFF0_FFF0_FFF0_FFF0}}) begin errors++; $display("FAIL or64_vx got %h want %h", res, {2{64'hFFF0_FFF0_FFF0_FFF0}}); end
    run_op(4'b1011, 3'b011, 2, 1'b1, 16'h0, {2{64'hF0F0_F0F0_F0F0_F0F0}}, '0, '0, 64'h0FF0_0FF0_0FF0_0FF0, res, ill, lat);
    checks++; if (res !== {2{64'hFF00_FF00_FF00_FF00}}) begin errors++; $display("FAIL xor64_vx got %h want %h", res, {2{64'hFF00_FF00_FF00_FF00}}); end
    // vl=0 leaves everything undisturbed
    run_op(4'b0000, 3'b000, 0, 1'b1, 16'h0, {16{8'h11}}, {16{8'h22}}, {8{16'h5A5A}}, 64'h0, res, ill, lat);
    checks++; if (res !== {8{16'h5A5A}}) begin errors++; $display("FAIL vl0 got %h want %h", res, {8{16'h5A5A}}); end
    checks++; if (lat !== NBEATS) begin errors++; $display("FAIL vl0_latency got %0d want %0d", lat, NBEATS); end
  endtask

  task automatic test_illegal();
    logic [VLEN-1:0] res;
    logic ill;
    int lat;
    run_op(4'b0000, 3'b100, 16, 1'b1, 16'h0, {16{8'h33}}, {16{8'h44}}, {16{8'h55}}, 64'h0, res, ill, lat);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_sew flag got %b want 1", ill); end
    checks++; if (res !== '0) begin errors++; $display("FAIL illegal_sew result got %h want 0", res); end
    checks++; if (lat !== NBEATS) begin errors++; $display("FAIL illegal_sew latency got %0d want %0d", lat, NBEATS); end
    run_op(4'b1100, 3'b000, 16, 1'b1, 16'h0, {16{8'h33}}, {16{8'h44}}, {16{8'h55}}, 64'h0, res, ill, lat);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_op flag got %b want 1", ill); end
    checks++; if (res !== '0) begin errors++; $display("FAIL illegal_op result got %h want 0", res); end
  endtask

  task automatic test_random();
    logic [VLEN-1:0] res, exp, in1, in2, old;
    logic [63:0] sc;
    logic [15:0] mask;
    logic [3:0] op;
    logic [2:0] sew;
    logic vm, ill, eill;
    int vl, lat;
    for (int t = 0; t < 40; t++) begin
      op   = 4'($urandom_range(0, 12));
      sew  = 3'($urandom_range(0, 4));
      vl   = $urandom_range(0, 20);
      vm   = 1'($urandom);
      mask = 16'($urandom);
      in1  = {$urandom, $urandom, $urandom, $urandom};
      in2  = {$urandom, $urandom, $urandom, $urandom};
      old  = {$urandom, $urandom, $urandom, $urandom};
      sc   = {$urandom, $urandom};
      exp  = model(op, sew, vl, vm, mask, in1, in2, old, sc, eill);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready[%0d] got %b want 1", t, bus.in_ready); end
      run_op(op, sew, vl, vm, mask, in1, in2, old, sc, res, ill, lat);
      checks++; if (res !== exp) begin errors++; $display("FAIL rand_result[%0d] op=%h sew=%0d vl=%0d vm=%b got %h want %h", t, op, sew, vl, vm, res, exp); end
      checks++; if (ill !== eill) begin errors++; $display("FAIL rand_illegal[%0d] got %b want %b", t, ill, eill); end
      checks++; if (lat !== NBEATS) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", t, lat, NBEATS); end
    end
  endtask

  task automatic test_backpressure();
    logic [VLEN-1:0] exp, in1, in2;
    logic eill;
    int lat;
    in1 = {$urandom, $urandom, $urandom, $urandom};
    in2 = {$urandom, $urandom, $urandom, $urandom};
    exp = model(4'b0100, 3'b001, 8, 1'b1, 16'h0, in1, in2, '0, 64'h0, eill);
    @(negedge clk);
    drive(4'b0100, 3'b001, 8, 1'b1, 16'h0, in1, in2, '0, 64'h0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    scramble_inputs();
    bus.valu_op = 4'b0000;
    bus.SEW = 3'b000;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== NBEATS) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, NBEATS); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL bp_hold_result[%0d] got %h want %h", c, bus.result, exp); end
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_ctrl[%0d] got in_ready=%b out_valid=%b want 0/1", c, bus.in_ready, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release got in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] ina, inb, expa, expb, got_a, got_b;
    logic eill;
    int first, second, pulses;
    ina = {$urandom, $urandom, $urandom, $urandom};
    inb = {$urandom, $urandom, $urandom, $urandom};
    expa = model(4'b0110, 3'b000, 16, 1'b1, 16'h0, ina, ~ina, '0, 64'h0, eill);
    expb = model(4'b0001, 3'b010, 16, 1'b1, 16'h0, inb, '0, '0, 64'h7, eill);
    @(negedge clk);
    drive(4'b0110, 3'b000, 16, 1'b1, 16'h0, ina, ~ina, '0, 64'h0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    drive(4'b0001, 3'b010, 16, 1'b1, 16'h0, inb, '0, '0, 64'h7);
    first = -1; second = -1; pulses = 0;
    got_a = '0; got_b = '0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (n == 4) bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin first = n; got_a = bus.result; end
        else begin second = n; got_b = bus.result; end
      end
    end
    bus.out_ready = 1'b0;
    checks++; if (first !== 2 || second !== 6 || pulses !== 2) begin errors++; $display("FAIL b2b_timing got first=%0d second=%0d pulses=%0d want 2/6/2", first, second, pulses); end
    checks++; if (got_a !== expa) begin errors++; $display("FAIL b2b_result_a got %h want %h", got_a, expa); end
    checks++; if (got_b !== expb) begin errors++; $display("FAIL b2b_result_b got %h want %h", got_b, expb); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    drive(4'b0000, 3'b000, 16, 1'b1, 16'h0, {16{8'h21}}, {16{8'h10}}, '0, 64'h0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got out_valid=%b in_ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL midrst_result got %h want 0", bus.result); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (bus.out_valid === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
